// File: rtl/lutram_reader.sv
// Readout master for the lutram sample memory: walks backwards from the newest sample and streams each word out.
// Optional abort input is enabled by defining LUTRAM_READER_ABORT_EN.
module lutram_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             start_i,
  input  logic [DEPTH-1:0] ptr_i,
  input  logic [DEPTH:0]   count_i,
`ifdef LUTRAM_READER_ABORT_EN
  input  logic             abort_i,
`endif
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [DEPTH-1:0] mem_addr_o,
  input  logic [WIDTH-1:0] mem_d_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_t;

  state_t           state, state_next;
  logic [DEPTH-1:0] addr;
  logic [DEPTH:0]   remaining;
  logic             abort;
  logic             active;

`ifdef LUTRAM_READER_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  // Abort only applies while a word is in flight; DONE always completes its pulse.
  assign active = (state == S_FETCH) || (state == S_CAPTURE) || (state == S_SEND);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: next-state defaults to the current state first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (start_i) begin
          state_next = (count_i != '0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH:   state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_SEND;
      S_SEND: begin
        if (ready_i) begin
          state_next = (remaining == (DEPTH+1)'(1)) ? S_DONE : S_FETCH;
        end
      end
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    if (abort && active) begin
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      addr      <= '0;
      remaining <= '0;
      data_o    <= '0;
    end else begin
      if (state == S_IDLE && start_i && count_i != '0) begin
        addr      <= ptr_i;
        remaining <= count_i;
      end
      if (state == S_CAPTURE) begin
        data_o <= mem_d_i;
      end
      // Address decrement wraps naturally at DEPTH bits, walking the circular buffer oldest-ward.
      if (state == S_SEND && ready_i && !abort) begin
        remaining <= remaining - (DEPTH+1)'(1);
        addr      <= addr - DEPTH'(1);
      end
    end
  end

  // Outputs decode the state register only, so valid_o has no combinational path from ready_i.
  assign mem_en_o   = (state == S_FETCH);
  assign mem_we_o   = 1'b0;
  assign mem_addr_o = addr;
  assign valid_o    = (state == S_SEND);
  assign busy_o     = (state != S_IDLE);
  assign done_o     = (state == S_DONE);

endmodule

// File: tb/tb_lutram_reader.sv
// Self-checking bench for lutram_reader: a RAM model plus a reference list of expected words
// computed as mem[(ptr - i) mod 16] for i in 0..count-1.
module tb_lutram_reader;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int NW    = 1 << DEPTH;

  logic             clk_i = 1'b0;
  logic             rst_in = 1'b0;
  logic             start_i = 1'b0;
  logic [DEPTH-1:0] ptr_i = '0;
  logic [DEPTH:0]   count_i = '0;
  logic             mem_en_o, mem_we_o;
  logic [DEPTH-1:0] mem_addr_o;
  logic [WIDTH-1:0] mem_d_i = '0;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             ready_i = 1'b0;
  logic             busy_o, done_o;

  lutram_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .rst_in     (rst_in),
    .start_i    (start_i),
    .ptr_i      (ptr_i),
    .count_i    (count_i),
    .mem_en_o   (mem_en_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_d_i    (mem_d_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  logic [WIDTH-1:0] mem [NW];
  always @(posedge clk_i) if (mem_en_o) mem_d_i <= mem[mem_addr_o];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk_i) cyc++;

  logic [WIDTH-1:0] words_q [$];
  int en_cnt, valid_cnt, done_cnt, we_cnt, first_valid_cyc, done_cyc, en_addr_hits[NW];

  always @(negedge clk_i) begin
    if (rst_in) begin
      if (mem_en_o) begin
        en_cnt++;
        en_addr_hits[mem_addr_o]++;
      end
      if (valid_o) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (valid_o && ready_i) words_q.push_back(data_o);
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (mem_we_o) we_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic clear_monitor();
    words_q.delete();
    en_cnt = 0; valid_cnt = 0; done_cnt = 0; we_cnt = 0;
    first_valid_cyc = -1; done_cyc = -1;
    for (int a = 0; a < NW; a++) en_addr_hits[a] = 0;
  endtask

  // Waits for completion, then scores the stream against the reference list.
  task automatic finish_and_score(input string tag, input int p, input int n, input bit rand_ready);
    int k = 0;
    logic [WIDTH-1:0] exp_q [$];
    while (done_cnt == 0 && k < 400) begin
      ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk_i); #1;
      k++;
    end
    ready_i = 1'b1;
    repeat (4) begin @(posedge clk_i); #1; end
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(p - i) & (NW - 1)]);
    check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    check({tag, "_words"}, 64'(words_q.size()), 64'(n));
    for (int i = 0; i < n && i < words_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 64'(words_q[i]), 64'(exp_q[i]));
    check({tag, "_en_pulses"}, 64'(en_cnt), 64'(n));
    check({tag, "_we_low"}, 64'(we_cnt), 64'd0);
    check({tag, "_idle"}, {62'd0, busy_o, valid_o}, 64'd0);
  endtask

  task automatic start_pulse(input int p, input int n, output int start_cyc);
    @(posedge clk_i); #1;
    start_i = 1'b1; ptr_i = DEPTH'(p); count_i = (DEPTH+1)'(n);
    start_cyc = cyc;
    @(posedge clk_i); #1;
    // Scrambled after acceptance: a running readout must not follow these.
    start_i = 1'b0; ptr_i = DEPTH'($urandom); count_i = (DEPTH+1)'($urandom);
  endtask

  task automatic run(input string tag, input int p, input int n, input bit rand_ready);
    int sc;
    clear_monitor();
    ready_i = 1'b1;
    start_pulse(p, n, sc);
    finish_and_score(tag, p, n, rand_ready);
    if (!rand_ready && n > 0) begin
      check({tag, "_first_valid_cyc"}, 64'(first_valid_cyc - sc), 64'd3);
      check({tag, "_done_cyc"}, 64'(done_cyc - sc), 64'(3 * n + 1));
    end
  endtask

  initial begin
    int sc, k;
    logic [WIDTH-1:0] held;
    for (int a = 0; a < NW; a++) mem[a] = 32'hA0 + a;
    clear_monitor();

    #1;
    check("rst_outputs", {58'd0, mem_en_o, mem_we_o, valid_o, busy_o, done_o, 1'b0}, 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    repeat (2) @(posedge clk_i);
    #2 rst_in = 1'b1;

    run("basic", 5, 3, 1'b0);
    run("wrap", 1, 4, 1'b0);
    run("full", 9, 16, 1'b0);
    for (int a = 0; a < NW; a++) check($sformatf("full_addr%0d_once", a), 64'(en_addr_hits[a]), 64'd1);

    // Zero count: straight to DONE with no RAM access or stream activity.
    clear_monitor();
    start_pulse(6, 0, sc);
    repeat (4) begin @(posedge clk_i); #1; end
    check("zero_done_once", 64'(done_cnt), 64'd1);
    check("zero_done_soon", 64'(done_cyc - sc <= 2 && done_cyc - sc >= 1), 64'd1);
    check("zero_no_en", 64'(en_cnt), 64'd0);
    check("zero_no_valid", 64'(valid_cnt), 64'd0);

    // Stall: hold ready low in SEND and pulse start while busy.
    clear_monitor();
    ready_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b1; ptr_i = 4'd3; count_i = 5'd3;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    k = 0;
    while (!valid_o && k < 20) begin @(posedge clk_i); #1; k++; end
    check("stall_reached_send", 64'(valid_o), 64'd1);
    held = data_o;
    check("stall_first_word", 64'(held), 64'hA3);
    for (int i = 0; i < 5; i++) begin
      start_i = (i == 2); ptr_i = 4'd12; count_i = 5'd16;
      @(posedge clk_i); #1;
      check($sformatf("stall_valid%0d", i), 64'(valid_o), 64'd1);
      check($sformatf("stall_data%0d", i), 64'(data_o), 64'(held));
    end
    start_i = 1'b0;
    finish_and_score("stall", 3, 3, 1'b0);

    // Reset during SEND of word 2 of 4.
    clear_monitor();
    ready_i = 1'b1;
    start_pulse(7, 4, sc);
    k = 0;
    while (!(words_q.size() == 1 && valid_o) && k < 50) begin @(posedge clk_i); #1; k++; end
    check("rstmid_in_word2", 64'(valid_o && words_q.size() == 1), 64'd1);
    #2 rst_in = 1'b0;
    #1;
    check("rstmid_async_drop", {61'd0, valid_o, busy_o, done_o}, 64'd0);
    repeat (2) @(posedge clk_i);
    #2 rst_in = 1'b1;
    repeat (4) begin @(posedge clk_i); #1; end
    check("rstmid_no_done", 64'(done_cnt), 64'd0);
    run("after_rst", 12, 3, 1'b1);

    for (int t = 0; t < 6; t++) begin
      int p = $urandom_range(0, NW - 1);
      int n = $urandom_range(1, NW);
      run($sformatf("rnd%0d", t), p, n, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
